// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: measures VGA line/frame geometry from sync+avr, locks after stable frames, flags deviations
module vga_timing_monitor #(
  parameter int H_CNT_W     = 11,
  parameter int V_CNT_W     = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               h_sync,
  input  logic               v_sync,
  input  logic               avr,
  output logic [H_CNT_W-1:0] h_total,
  output logic [H_CNT_W-1:0] h_sync_len,
  output logic [H_CNT_W-1:0] h_active,
  output logic [V_CNT_W-1:0] v_total,
  output logic [V_CNT_W-1:0] v_sync_len,
  output logic [V_CNT_W-1:0] v_active,
  output logic               locked,
  output logic               frame_pulse,
  output logic               timing_err
);
  localparam int TW = 2 * H_CNT_W + 2 * V_CNT_W;
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [H_CNT_W-1:0] HMAX = '1;
  localparam logic [V_CNT_W-1:0] VMAX = '1;
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
  state_t state_q;
  logic hs1_q, hs2_q, vs1_q, vs2_q, as1_q;
  logic [H_CNT_W-1:0] hcnt_q, hlow_q, acnt_q, h_total_q, h_sync_len_q, h_active_q;
  logic [H_CNT_W-1:0] hcnt_d, hlow_d, acnt_d, h_total_d, h_sync_len_d, h_active_d;
  logic [V_CNT_W-1:0] lcnt_q, lcnt_act_q, vlow_q, v_total_q, v_sync_len_q, v_active_q;
  logic [V_CNT_W-1:0] lcnt_d, lcnt_act_d, vlow_d, v_total_d, v_sync_len_d, v_active_d;
  logic [V_CNT_W-1:0] lcnt_h, lact_h, vlow_h;
  logic [TW-1:0] snap_q, tuple;
  logic [MW-1:0] match_q;
  logic locked_q, frame_pulse_q, timing_err_q;
  logic h_fall, h_rise, v_fall, v_rise, act_line, sat, same, h_bad;
  always_comb begin
    h_fall       = hs2_q & ~hs1_q;
    h_rise       = ~hs2_q & hs1_q;
    v_fall       = vs2_q & ~vs1_q;
    v_rise       = ~vs2_q & vs1_q;
    act_line     = h_fall & (acnt_q != '0);
    hcnt_d       = h_fall ? H_CNT_W'(1) : (hcnt_q == HMAX) ? hcnt_q : hcnt_q + 1'b1;
    hlow_d       = h_rise ? '0 : (!hs1_q && hlow_q != HMAX) ? hlow_q + 1'b1 : hlow_q;
    acnt_d       = h_fall ? '0 : (as1_q && acnt_q != HMAX) ? acnt_q + 1'b1 : acnt_q;
    h_total_d    = h_fall ? hcnt_q : h_total_q;
    h_sync_len_d = h_rise ? hlow_q : h_sync_len_q;
    h_active_d   = act_line ? acnt_q : h_active_q;
    // the h fall of a coincident h/v fall belongs to the frame that is closing
    lcnt_h       = (h_fall && lcnt_q != VMAX) ? lcnt_q + 1'b1 : lcnt_q;
    lact_h       = (act_line && lcnt_act_q != VMAX) ? lcnt_act_q + 1'b1 : lcnt_act_q;
    vlow_h       = (h_fall && !vs1_q && vlow_q != VMAX) ? vlow_q + 1'b1 : vlow_q;
    lcnt_d       = v_fall ? '0 : lcnt_h;
    lcnt_act_d   = v_fall ? '0 : lact_h;
    vlow_d       = v_rise ? '0 : vlow_h;
    v_total_d    = v_fall ? lcnt_h : v_total_q;
    v_active_d   = v_fall ? lact_h : v_active_q;
    v_sync_len_d = v_rise ? vlow_q : v_sync_len_q;
    // saturation fires once, on the cycle a counter reaches its ceiling
    sat          = (!h_fall && hcnt_q == HMAX - 1'b1) || (h_fall && !v_fall && lcnt_q == VMAX - 1'b1);
    tuple        = {h_total_d, h_sync_len_d, v_total_d, v_sync_len_d};
    same         = tuple == snap_q;
    h_bad        = h_fall && hcnt_q != snap_q[TW-1 -: H_CNT_W];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {hs1_q, hs2_q, vs1_q, vs2_q, as1_q} <= 5'b11110;
      {hcnt_q, hlow_q, acnt_q, h_total_q, h_sync_len_q, h_active_q} <= '0;
      {lcnt_q, lcnt_act_q, vlow_q, v_total_q, v_sync_len_q, v_active_q} <= '0;
      frame_pulse_q <= 1'b0;
    end else begin
      {hs1_q, hs2_q, vs1_q, vs2_q, as1_q} <= {h_sync, hs1_q, v_sync, vs1_q, avr};
      {hcnt_q, hlow_q, acnt_q, h_total_q, h_sync_len_q, h_active_q} <=
        {hcnt_d, hlow_d, acnt_d, h_total_d, h_sync_len_d, h_active_d};
      {lcnt_q, lcnt_act_q, vlow_q, v_total_q, v_sync_len_q, v_active_q} <=
        {lcnt_d, lcnt_act_d, vlow_d, v_total_d, v_sync_len_d, v_active_d};
      frame_pulse_q <= v_fall;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= SEARCH;
      match_q      <= '0;
      snap_q       <= '0;
      locked_q     <= 1'b0;
      timing_err_q <= 1'b0;
    end else begin
      timing_err_q <= 1'b0;
      case (state_q)
        SEARCH:
          if (sat) timing_err_q <= 1'b1;
          else if (v_fall) begin
            state_q <= CHECK;
            match_q <= '0;
            snap_q  <= tuple;
          end
        CHECK:
          if (sat) begin
            timing_err_q <= 1'b1;
            state_q      <= SEARCH;
          end else if (v_fall && same) begin
            match_q <= match_q + 1'b1;
            if (match_q + 1'b1 == MW'(LOCK_FRAMES)) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end else if (v_fall) begin
            match_q <= '0;
            snap_q  <= tuple;
          end
        LOCKED:
          if (sat || h_bad || (v_fall && !same)) begin
            state_q      <= SEARCH;
            locked_q     <= 1'b0;
            timing_err_q <= 1'b1;
          end
        default: state_q <= SEARCH;
      endcase
    end
  assign h_total     = h_total_q;
  assign h_sync_len  = h_sync_len_q;
  assign h_active    = h_active_q;
  assign v_total     = v_total_q;
  assign v_sync_len  = v_sync_len_q;
  assign v_active    = v_active_q;
  assign locked      = locked_q;
  assign frame_pulse = frame_pulse_q;
  assign timing_err  = timing_err_q;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed scoreboard bench for vga_timing_monitor
module tb_vga_timing_monitor;
  logic clk = 1'b0, rst_n = 1'b0, h_sync = 1'b1, v_sync = 1'b1, avr = 1'b0;
  logic [10:0] h_total, h_sync_len, h_active;
  logic [9:0] v_total, v_sync_len, v_active;
  logic locked, frame_pulse, timing_err;
  typedef struct {int ht, hs, ho, ha, vt, vs, vo, va;} mode_t;
  typedef struct {bit chk; int ht, hs, ha, vt, vs, va; bit lk; int gap;} rec_t;
  rec_t q[$];
  int vectors = 0, errors = 0, err_cnt = 0, clk_n = 0, last_pulse = 0;
  logic te_prev = 1'b0;
  vga_timing_monitor #(.H_CNT_W(11), .V_CNT_W(10), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .h_sync(h_sync), .v_sync(v_sync), .avr(avr),
    .h_total(h_total), .h_sync_len(h_sync_len), .h_active(h_active),
    .v_total(v_total), .v_sync_len(v_sync_len), .v_active(v_active),
    .locked(locked), .frame_pulse(frame_pulse), .timing_err(timing_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) clk_n++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    rec_t r;
    if (timing_err) begin
      err_cnt++;
      check("err_locked_low", {31'd0, locked}, 0);
      check("err_one_cycle", {31'd0, te_prev}, 0);
    end
    te_prev = timing_err;
    if (frame_pulse) begin
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $error("FAIL pulse_unexpected: observed frame_pulse, expected none");
      end else begin
        r = q.pop_front();
        if (r.chk) begin
          check("h_total", {21'd0, h_total}, r.ht);
          check("h_sync_len", {21'd0, h_sync_len}, r.hs);
          check("h_active", {21'd0, h_active}, r.ha);
          check("v_total", {22'd0, v_total}, r.vt);
          check("v_sync_len", {22'd0, v_sync_len}, r.vs);
          check("v_active", {22'd0, v_active}, r.va);
        end
        check("locked_at_pulse", {31'd0, locked}, {31'd0, r.lk});
        if (r.gap != 0) check("frame_gap", clk_n - last_pulse, r.gap);
      end
      last_pulse = clk_n;
    end
  end
  task automatic gen(input mode_t m, input int nfr, input int extra, input int sy, input rec_t first, input int mask);
    int n = 0, lastv = 0, idx = 0, fc = 0;
    rec_t r;
    for (int f = 0; f <= nfr; f++)
      for (int y = 0; y < m.vt; y++)
        for (int x = 0; x < m.ht + ((f == 0 && y == sy) ? 5 : 0); x++) begin
          if (x == 0 && y == 0) fc = 0;
          if (f == nfr && fc >= extra) return;
          @(negedge clk);
          h_sync = !(x < m.hs);
          v_sync = !(y < m.vs);
          avr = x >= m.ho && x < m.ho + m.ha && y >= m.vo && y < m.vo + m.va;
          if (x == 0 && y == 0) begin
            if (idx == 0) begin
              r = first;
              r.gap = 0;
            end else r = '{1'b1, m.ht, m.hs, m.ha, m.vt, m.vs, m.va, 1'b0, n - lastv};
            r.lk = mask[idx];
            q.push_back(r);
            lastv = n;
            idx++;
          end
          fc++;
          n++;
        end
  endtask
  task automatic check_zero(input string where);
    check({where, "_h_total"}, {21'd0, h_total}, 0);
    check({where, "_h_sync_len"}, {21'd0, h_sync_len}, 0);
    check({where, "_h_active"}, {21'd0, h_active}, 0);
    check({where, "_v_total"}, {22'd0, v_total}, 0);
    check({where, "_v_sync_len"}, {22'd0, v_sync_len}, 0);
    check({where, "_v_active"}, {22'd0, v_active}, 0);
    check({where, "_locked"}, {31'd0, locked}, 0);
    check({where, "_frame_pulse"}, {31'd0, frame_pulse}, 0);
    check({where, "_timing_err"}, {31'd0, timing_err}, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    mode_t a, b;
    rec_t rz, ra, rb, rs;
    int e0;
    a  = '{40, 6, 10, 24, 12, 2, 3, 8};
    b  = '{50, 8, 12, 32, 15, 3, 4, 10};
    rz = '{1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 0};
    ra = '{1'b1, a.ht, a.hs, a.ha, a.vt, a.vs, a.va, 1'b0, 0};
    rb = '{1'b1, b.ht, b.hs, b.ha, b.vt, b.vs, b.va, 1'b0, 0};
    rs = '{1'b1, 2047, b.hs, b.ha, b.vt, b.vs, b.va, 1'b0, 0};
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    e0 = err_cnt;
    gen(a, 6, 0, -1, rz, 'b111000);
    check("acquire_errs", err_cnt - e0, 0);
    check("acquire_drain", q.size(), 0);
    e0 = err_cnt;
    gen(a, 5, 0, 3, ra, 'b11001);
    check("stretch_errs", err_cnt - e0, 1);
    e0 = err_cnt;
    gen(b, 5, 0, -1, ra, 'b11001);
    check("mode_errs", err_cnt - e0, 1);
    check("mode_locked", {31'd0, locked}, 1);
    e0 = err_cnt;
    repeat (2100) @(negedge clk);
    check("sat_errs", err_cnt - e0, 1);
    check("sat_locked", {31'd0, locked}, 0);
    check("sat_h_total", {21'd0, h_total}, b.ht);
    check("sat_h_sync_len", {21'd0, h_sync_len}, b.hs);
    check("sat_h_active", {21'd0, h_active}, b.ha);
    check("sat_v_total", {22'd0, v_total}, b.vt);
    check("sat_v_sync_len", {22'd0, v_sync_len}, b.vs);
    check("sat_v_active", {22'd0, v_active}, b.va);
    e0 = err_cnt;
    gen(b, 5, 0, -1, rs, 'b11000);
    check("resume_errs", err_cnt - e0, 0);
    e0 = err_cnt;
    gen(a, 2, 17, -1, rb, 'b001);
    check("switch_errs", err_cnt - e0, 1);
    check("switch_drain", q.size(), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async");
    h_sync = 1'b1;
    v_sync = 1'b1;
    avr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e0 = err_cnt;
    gen(a, 6, 0, -1, rz, 'b111000);
    check("relock_errs", err_cnt - e0, 0);
    repeat (10) @(negedge clk);
    check("final_locked", {31'd0, locked}, 1);
    check("final_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
